// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader slice.
package mips_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    S_LOAD,
    S_WRITE,
    S_DONE
  } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Program byte stream (valid/ready) feeding the instruction-memory loader.
interface imem_loader_if;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic       in_last;

  modport master (
    output in_valid,
    output in_byte,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_byte,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes into big-endian 32-bit words; a word closed early by
// in_last is zero-padded in its low bytes.
module byte_packer
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              accept,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  output logic              word_done,
  output logic [WORD_W-1:0] word
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] shifted;
  logic [4:0]  pad_sh;

  // Shift new byte in at the LSB end; emit the padded word on the closing byte.
  always_comb begin
    shifted    = {shift_q, in_byte};
    pad_sh     = {2'd3 - byte_cnt_q, 3'b000};
    word       = shifted << pad_sh;
    word_done  = accept & ((byte_cnt_q == 2'd3) | in_last);
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    if (clr) begin
      byte_cnt_d = '0;
      shift_d    = '0;
    end else if (accept) begin
      if (word_done) begin
        byte_cnt_d = '0;
        shift_d    = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        shift_d    = shifted[23:0];
      end
    end
  end

  // Packer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
      shift_q    <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a program byte stream into instruction RAM from word 0 upward and
// holds the CPU in reset until the last word is written.
module imem_loader
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic               clk,
  input  logic               rst,
  imem_loader_if.slave       stream,
  input  logic               load_start,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [WORD_W-1:0]  ram_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               overflow,
  output logic [ADDR_W:0]    word_count
);

  loader_state_e     state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              last_q, last_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [WORD_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic [ADDR_W:0]   word_idx_q, word_idx_d;

  logic              accept;
  logic              packer_clr;
  logic              word_done;
  logic [WORD_W-1:0] word;

  assign accept          = stream.in_valid & in_ready_q;
  assign stream.in_ready = in_ready_q;
  assign ram_we          = ram_we_q;
  assign ram_addr        = ram_addr_q;
  assign ram_wdata       = ram_wdata_q;
  assign cpu_hold        = cpu_hold_q;
  assign done            = done_q;
  assign overflow        = overflow_q;
  assign word_count      = word_idx_q;

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (packer_clr),
    .accept    (accept),
    .in_byte   (stream.in_byte),
    .in_last   (stream.in_last),
    .word_done (word_done),
    .word      (word)
  );

  // FSM next state and registered RAM/CPU-facing outputs.
  // The write decision is made on the completing accept so that the strobe
  // is already registered for the single S_WRITE cycle.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    last_d      = last_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    done_d      = done_q;
    overflow_d  = overflow_q;
    word_idx_d  = word_idx_q;
    packer_clr  = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (word_done) begin
          state_d    = S_WRITE;
          in_ready_d = 1'b0;
          last_d     = stream.in_last;
          if (word_idx_q < (ADDR_W+1)'(DEPTH)) begin
            ram_we_d    = 1'b1;
            ram_addr_d  = word_idx_q[ADDR_W-1:0];
            ram_wdata_d = word;
            word_idx_d  = word_idx_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (last_q) begin
          state_d    = S_DONE;
          in_ready_d = 1'b0;
          cpu_hold_d = 1'b0;
          done_d     = 1'b1;
        end else begin
          state_d    = S_LOAD;
          in_ready_d = 1'b1;
        end
      end
      S_DONE: begin
        if (load_start) begin
          state_d    = S_LOAD;
          in_ready_d = 1'b1;
          cpu_hold_d = 1'b1;
          done_d     = 1'b0;
          overflow_d = 1'b0;
          word_idx_d = '0;
          last_d     = 1'b0;
          packer_clr = 1'b1;
        end
      end
      default: begin
        state_d    = S_LOAD;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      in_ready_q  <= 1'b1;
      last_q      <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      word_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      last_q      <= last_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      word_idx_q  <= word_idx_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: two instances (full depth and DEPTH=4)
// driven from one byte-stream driver, checked against a word-level model.
module tb_imem_loader;
  import mips_pkg::*;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if s0 ();
  imem_loader_if s1 ();

  logic        sel;
  logic        d_valid, d_last, d_ls;
  logic [7:0]  d_byte;
  logic        ls0, ls1;

  logic        we0, we1, hold0, hold1, done0, done1, ovf0, ovf1;
  logic [7:0]  addr0, addr1;
  logic [31:0] wd0, wd1;
  logic [8:0]  wc0, wc1;

  assign s0.in_valid = d_valid & ~sel;
  assign s0.in_byte  = d_byte;
  assign s0.in_last  = d_last;
  assign s1.in_valid = d_valid & sel;
  assign s1.in_byte  = d_byte;
  assign s1.in_last  = d_last;
  assign ls0         = d_ls & ~sel;
  assign ls1         = d_ls & sel;

  imem_loader #(.ADDR_W(8), .DEPTH(256)) u_dut0 (
    .clk(clk), .rst(rst), .stream(s0.slave), .load_start(ls0),
    .ram_we(we0), .ram_addr(addr0), .ram_wdata(wd0), .cpu_hold(hold0),
    .done(done0), .overflow(ovf0), .word_count(wc0)
  );

  imem_loader #(.ADDR_W(8), .DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .stream(s1.slave), .load_start(ls1),
    .ram_we(we1), .ram_addr(addr1), .ram_wdata(wd1), .cpu_hold(hold1),
    .done(done1), .overflow(ovf1), .word_count(wc1)
  );

  logic        m_ready, m_we, m_hold, m_done, m_ovf;
  logic [7:0]  m_addr;
  logic [31:0] m_wd;
  logic [8:0]  m_wc;

  assign m_ready = sel ? s1.in_ready : s0.in_ready;
  assign m_we    = sel ? we1   : we0;
  assign m_addr  = sel ? addr1 : addr0;
  assign m_wd    = sel ? wd1   : wd0;
  assign m_hold  = sel ? hold1 : hold0;
  assign m_done  = sel ? done1 : done0;
  assign m_ovf   = sel ? ovf1  : ovf0;
  assign m_wc    = sel ? wc1   : wc0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Drives prog into the selected DUT and checks the resulting RAM writes
  // against a word-level model. stop_after >= 0 abandons the load after that
  // many accepted bytes without final checks.
  task automatic run_program(input byte_q_t prog, input bit gaps, input int depth,
                             input int stop_after);
    logic [31:0] exp_w[$];
    logic [31:0] got_d[$];
    int          got_a[$];
    int          n, nw, idx, pend_word, cyc;
    bit          pend, fin;
    logic [31:0] w;
    n  = prog.size();
    nw = (n + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      w = 32'h0;
      for (int b = 0; b < 4; b++)
        w = (w * 256) + ((4*k + b < n) ? 32'(prog[4*k + b]) : 32'h0);
      exp_w.push_back(w);
    end
    idx = 0; pend = 0; pend_word = 0; cyc = 0; fin = 0;
    d_valid = 1'b0; d_last = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (m_we) begin
        got_a.push_back(int'(m_addr));
        got_d.push_back(m_wd);
      end
      if (pend) begin
        check("write_strobe_latency", m_we, (pend_word < depth));
        check("ready_low_in_write", m_ready, 1'b0);
        check("hold_while_loading", m_hold, 1'b1);
        pend = 0;
      end
      if (stop_after >= 0 && idx >= stop_after) fin = 1;
      else if (idx == n && m_done) fin = 1;
      else if (cyc > 4000) begin
        check("timeout_done", m_done, 1'b1);
        fin = 1;
      end
      if (!fin && idx < n) begin
        d_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
        d_byte  = prog[idx];
        d_last  = (idx == n - 1);
        if (d_valid && m_ready) begin
          idx++;
          if (idx % 4 == 0 || idx == n) begin
            pend      = 1;
            pend_word = (idx - 1) / 4;
          end
        end
      end else begin
        d_valid = 1'b0;
        d_last  = 1'b0;
      end
    end
    d_valid = 1'b0;
    d_last  = 1'b0;
    if (stop_after < 0) begin
      check("num_writes", got_d.size(), min_i(nw, depth));
      for (int i = 0; i < got_d.size() && i < exp_w.size(); i++) begin
        check($sformatf("addr[%0d]", i), got_a[i], i);
        check($sformatf("wdata[%0d]", i), got_d[i], exp_w[i]);
      end
      check("word_count", m_wc, min_i(nw, depth));
      check("overflow", m_ovf, (nw > depth));
      check("done", m_done, 1'b1);
      check("cpu_hold_released", m_hold, 1'b0);
      check("ready_low_in_done", m_ready, 1'b0);
    end
  endtask

  task automatic restart();
    @(negedge clk);
    d_ls = 1'b1;
    @(negedge clk);
    d_ls = 1'b0;
    check("restart_hold", m_hold, 1'b1);
    check("restart_done", m_done, 1'b0);
    check("restart_overflow", m_ovf, 1'b0);
    check("restart_word_count", m_wc, 0);
    check("restart_ready", m_ready, 1'b1);
  endtask

  function automatic byte_q_t rand_prog(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  initial begin
    byte_q_t p;
    int      stray;
    rst = 1'b1; sel = 1'b0;
    d_valid = 1'b0; d_last = 1'b0; d_ls = 1'b0; d_byte = 8'h00;
    #12;
    check("rst_ram_we", we0, 1'b0);
    check("rst_ram_addr", addr0, 0);
    check("rst_ram_wdata", wd0, 0);
    check("rst_cpu_hold", hold0, 1'b1);
    check("rst_done", done0, 1'b0);
    check("rst_overflow", ovf0, 1'b0);
    check("rst_word_count", wc0, 0);
    @(negedge clk);
    rst = 1'b0;

    p = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8D, 8'h09, 8'h00, 8'h00};
    run_program(p, 0, 256, -1);

    restart();
    p = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    run_program(p, 0, 256, -1);

    restart();
    p = rand_prog(int'($urandom_range(5, 40)));
    run_program(p, 0, 256, -1);
    restart();
    run_program(p, 1, 256, -1);

    restart();
    p = '{8'hBB};
    run_program(p, 1, 256, -1);

    // Bytes offered in S_DONE must be ignored.
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m_we || m_ready) stray++;
      d_valid = 1'b1;
      d_byte  = 8'($urandom);
      d_last  = 1'b1;
    end
    @(negedge clk);
    if (m_we || m_ready) stray++;
    d_valid = 1'b0; d_last = 1'b0;
    check("done_ignores_bytes", stray, 0);
    check("done_word_count_kept", m_wc, 1);

    // Overflow on the DEPTH=4 instance.
    sel = 1'b1;
    p = rand_prog(24);
    run_program(p, 1, 4, -1);
    sel = 1'b0;

    restart();
    p = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_program(p, 1, 256, -1);

    // Asynchronous reset in the middle of the second word.
    restart();
    p = rand_prog(8);
    run_program(p, 0, 256, 6);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ram_we", we0, 1'b0);
    check("async_rst_ram_addr", addr0, 0);
    check("async_rst_ram_wdata", wd0, 0);
    check("async_rst_cpu_hold", hold0, 1'b1);
    check("async_rst_done", done0, 1'b0);
    check("async_rst_overflow", ovf0, 1'b0);
    check("async_rst_word_count", wc0, 0);
    check("async_rst_ready", s0.in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    p = rand_prog(4);
    run_program(p, 1, 256, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
